// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside the ID stage: load-use stalls, taken-branch
// flushes and multi-cycle mul/div front-end holds, with a saturating stall counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             ID_branch_taken_i,
  input  logic             ID_muldiv_i,
  output logic             IFIDwrite_o,
  output logic             IFIDflush_o,
  output logic             PCwrite_o,
  output logic             IDEXbubble_o,
  output logic             busy_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int CW = (MD_LAT <= 2) ? 1 : $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             load_use_s;
  logic             hold_s;
  logic             flush_s;

  assign load_use_s = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                      ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

  // Next-state and Mealy hold/flush decode; load-use outranks a branch whose operand is stale
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hold_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (load_use_s) begin
          hold_s = 1'b1;
        end else if (ID_branch_taken_i) begin
          flush_s = 1'b1;
        end else if (ID_muldiv_i) begin
          hold_s      = 1'b1;
          state_nxt_s = MDWAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          hold_s = 1'b0;
        end
      end
      MDWAIT: begin
        hold_s = 1'b1;
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = ISSUE;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      ISSUE: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and mul/div occupancy counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= RUN;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating count of cycles in which IF/ID was held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign IFIDwrite_o  = hold_s  & ~rst_i;
  assign PCwrite_o    = hold_s  & ~rst_i;
  assign IDEXbubble_o = hold_s  & ~rst_i;
  assign IFIDflush_o  = flush_s & ~rst_i;
  assign busy_o       = (state_r == MDWAIT);
  assign state_o      = state_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule
